// File: rtl/fx2_fifo_ctrl.sv
// rtl/fx2_fifo_ctrl.sv - FX2 synchronous slave-FIFO master: EP2 reads, EP6 writes, PKTEND timeout
// Shares the 16-bit FX2 bus between the rx and tx streams with a dead cycle at every turnaround.
module fx2_fifo_ctrl #(
    parameter int         PKT_WORDS      = 256,
    parameter int         MAX_BURST      = 64,
    parameter int         PKTEND_TIMEOUT = 1024,
    parameter logic [1:0] EP_RX_ADDR     = 2'b00,
    parameter logic [1:0] EP_TX_ADDR     = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] fd_in,
    output logic [15:0] fd_out,
    output logic        fd_oe,
    output logic        sloe_n,
    output logic        slrd_n,
    output logic        slwr_n,
    output logic        pktend_n,
    output logic [1:0]  fifoadr,
    input  logic        ep2_empty_n,
    input  logic        ep6_full_n,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int PW = $clog2(PKT_WORDS);
    localparam int IW = $clog2(PKTEND_TIMEOUT + 1);

    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [PW-1:0] PKT_LAST   = PW'(PKT_WORDS - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(PKTEND_TIMEOUT);
    localparam logic [IW-1:0] IDLE_PRE   = IW'(PKTEND_TIMEOUT - 1);

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_SEL,
        RD,
        WR_SEL,
        WR,
        PKTEND
    } state_t;

    state_t        state;
    logic [BW-1:0] burst_cnt;
    logic [PW-1:0] pkt_cnt;
    logic [IW-1:0] idle_cnt;
    logic          pend_pktend;
    logic          last_grant;

    logic pe_req;
    logic rd_req;
    logic wr_req;

    // Strobes follow the live flags so a flag drop never produces a strobe in that cycle.
    assign rx_valid = (state == RD) & ep2_empty_n & rx_ready;
    assign slrd_n   = ~rx_valid;
    assign tx_ready = (state == WR) & ep6_full_n & tx_valid;
    assign slwr_n   = ~tx_ready;
    assign rx_data  = fd_in;
    assign fd_out   = tx_data;

    assign pe_req = pend_pktend & ep6_full_n;
    assign rd_req = ep2_empty_n & rx_ready;
    assign wr_req = ep6_full_n & tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sloe_n      <= 1'b1;
            pktend_n    <= 1'b1;
            fd_oe       <= 1'b0;
            fifoadr     <= EP_RX_ADDR;
            burst_cnt   <= '0;
            pkt_cnt     <= '0;
            idle_cnt    <= '0;
            pend_pktend <= 1'b0;
            last_grant  <= GRANT_WR;
        end else begin
            // A write restarts the short-packet timer and cancels any pending commit.
            if (tx_ready) begin
                idle_cnt    <= '0;
                pend_pktend <= 1'b0;
                pkt_cnt     <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
            end else if (pkt_cnt != '0 && idle_cnt != IDLE_LIMIT) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == IDLE_PRE) begin
                    pend_pktend <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (pe_req) begin
                        state    <= PKTEND;
                        fifoadr  <= EP_TX_ADDR;
                        pktend_n <= 1'b0;
                        fd_oe    <= 1'b0;
                        sloe_n   <= 1'b1;
                    end else if (rd_req && (!wr_req || last_grant == GRANT_WR)) begin
                        state   <= RD_SEL;
                        fifoadr <= EP_RX_ADDR;
                        sloe_n  <= 1'b0;
                        fd_oe   <= 1'b0;
                    end else if (wr_req) begin
                        state   <= WR_SEL;
                        fifoadr <= EP_TX_ADDR;
                        sloe_n  <= 1'b1;
                        fd_oe   <= 1'b1;
                    end
                end
                RD_SEL: begin
                    state     <= RD;
                    burst_cnt <= '0;
                end
                RD: begin
                    if (rx_valid) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (!rx_valid || burst_cnt == BURST_LAST) begin
                        state      <= IDLE;
                        sloe_n     <= 1'b1;
                        last_grant <= GRANT_RD;
                        burst_cnt  <= '0;
                    end
                end
                WR_SEL: begin
                    state     <= WR;
                    burst_cnt <= '0;
                end
                WR: begin
                    if (tx_ready) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (!tx_ready || burst_cnt == BURST_LAST) begin
                        state      <= IDLE;
                        fd_oe      <= 1'b0;
                        last_grant <= GRANT_WR;
                        burst_cnt  <= '0;
                    end
                end
                PKTEND: begin
                    state       <= IDLE;
                    pktend_n    <= 1'b1;
                    pend_pktend <= 1'b0;
                    pkt_cnt     <= '0;
                    idle_cnt    <= '0;
                    burst_cnt   <= '0;
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fx2_fifo_ctrl.sv
// tb/tb_fx2_fifo_ctrl.sv - scoreboard bench for fx2_fifo_ctrl with an FX2 host-side model
// Expected words are queued at stimulus time; a negedge monitor pops them on every bus strobe.
module tb_fx2_fifo_ctrl;

    localparam int T     = 1024;
    localparam int BURST = 64;
    localparam int PKT   = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fd_in;
    logic [15:0] fd_out;
    logic        fd_oe;
    logic        sloe_n;
    logic        slrd_n;
    logic        slwr_n;
    logic        pktend_n;
    logic [1:0]  fifoadr;
    logic        ep2_empty_n;
    logic        ep6_full_n;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    fx2_fifo_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fd_in       (fd_in),
        .fd_out      (fd_out),
        .fd_oe       (fd_oe),
        .sloe_n      (sloe_n),
        .slrd_n      (slrd_n),
        .slwr_n      (slwr_n),
        .pktend_n    (pktend_n),
        .fifoadr     (fifoadr),
        .ep2_empty_n (ep2_empty_n),
        .ep6_full_n  (ep6_full_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int side;
        int len;
        int gap;
        bit post_ok;
    } run_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] host_q[$];
    logic [15:0] exp_rx[$];
    logic [15:0] src_q[$];
    logic [15:0] exp_tx[$];
    run_t        runs[$];

    bit ep2_gate, ep6_gate, rdy_gate, txv_gate, rand_mode;
    int bp_at  = -1;
    int bp_len = 0;
    int wcount = 0;
    int pe_count = 0;
    int last_wr_cyc = 0;
    int pe_delay = 0;
    int host_pkt = 0;
    logic [15:0] seq = 16'h0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            ep2_gate = ($urandom_range(0, 3) != 0);
            ep6_gate = ($urandom_range(0, 3) != 0);
            rdy_gate = ($urandom_range(0, 4) != 0);
            txv_gate = ($urandom_range(0, 2) != 0);
        end
        ep2_empty_n = (host_q.size() > 0) && ep2_gate;
        fd_in       = (host_q.size() > 0) ? host_q[0] : 16'hdead;
        rx_ready    = rdy_gate;
        tx_valid    = (src_q.size() > 0) && txv_gate;
        tx_data     = (src_q.size() > 0) ? src_q[0] : 16'h0;
        if (bp_at >= 0 && wcount >= bp_at) begin
            ep6_full_n = 1'b0;
            bp_len--;
            if (bp_len <= 0) bp_at = -1;
        end else begin
            ep6_full_n = ep6_gate;
        end
    endtask

    task automatic push_tx(input int n);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(seq);
            exp_tx.push_back(seq);
            seq = seq + 16'h1;
        end
    endtask

    task automatic push_rx(input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            host_q.push_back(w);
            exp_rx.push_back(w);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_rx.size() > 0 || exp_tx.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk(exp_rx.size() == 0 && exp_tx.size() == 0, name, exp_rx.size() + exp_tx.size(), 0);
    endtask

    // Bus monitor: FX2 host model plus scoreboard, sampled mid-cycle.
    initial begin : monitor
        int  cur_side;
        int  cur_len;
        int  cur_gap;
        int  last_end;
        int  side;
        bit  prev_sloe;
        bit  prev_oe;
        run_t r;
        cur_side = 0; cur_len = 0; cur_gap = 0; last_end = 0;
        prev_sloe = 1'b1; prev_oe = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                cur_side = 0;
                prev_sloe = 1'b1;
                prev_oe = 1'b0;
                continue;
            end
            chk(!(fd_oe && !sloe_n), "bus_contention", int'(fd_oe), 0);
            if (!ep6_full_n || !ep2_empty_n)
                chk((ep6_full_n || slwr_n) && (ep2_empty_n || slrd_n), "strobe_on_flag",
                    int'({slrd_n, slwr_n}), 3);
            if (!slrd_n) begin
                chk(rx_valid && rx_ready && !sloe_n && fifoadr == 2'b00 && !fd_oe && slwr_n,
                    "rd_bus", int'({rx_valid, sloe_n, fifoadr, fd_oe}), 5'b10000);
                if (exp_rx.size() == 0) chk(1'b0, "rx_unexpected", int'(rx_data), 0);
                else begin
                    chk(rx_data == exp_rx[0], "rx_data", int'(rx_data), int'(exp_rx[0]));
                    void'(exp_rx.pop_front());
                    void'(host_q.pop_front());
                end
            end
            if (!slwr_n) begin
                chk(fd_oe && fifoadr == 2'b10 && tx_ready, "wr_bus",
                    int'({fd_oe, fifoadr, tx_ready}), 4'b1101);
                if (exp_tx.size() == 0) chk(1'b0, "tx_unexpected", int'(fd_out), 0);
                else begin
                    chk(fd_out == exp_tx[0], "tx_seq", int'(fd_out), int'(exp_tx[0]));
                    void'(exp_tx.pop_front());
                    void'(src_q.pop_front());
                end
                wcount++;
                host_pkt = (host_pkt + 1) % PKT;
                last_wr_cyc = cyc;
            end
            if (!pktend_n) begin
                chk(host_pkt != 0, "pktend_nonempty", host_pkt, 1);
                chk(fifoadr == 2'b10 && !fd_oe && slwr_n, "pktend_bus",
                    int'({fifoadr, fd_oe}), 3'b100);
                pe_count++;
                pe_delay = cyc - last_wr_cyc;
                host_pkt = 0;
            end
            side = !slrd_n ? 1 : (!slwr_n ? 2 : 0);
            if (side != cur_side) begin
                if (cur_side != 0) begin
                    r.side = cur_side; r.len = cur_len; r.gap = cur_gap;
                    r.post_ok = sloe_n && !fd_oe;
                    runs.push_back(r);
                    last_end = cyc - 1;
                end
                if (side != 0) begin
                    cur_len = 0;
                    cur_gap = cyc - last_end - 1;
                    if (side == 1) chk(!prev_sloe && !prev_oe, "rd_sel_cycle", int'({prev_sloe, prev_oe}), 0);
                    else chk(prev_oe, "wr_sel_cycle", int'(prev_oe), 1);
                end
                cur_side = side;
            end
            if (side != 0) cur_len++;
            prev_sloe = sloe_n;
            prev_oe = fd_oe;
        end
    end

    initial begin : stimulus
        int pe0;
        int n;
        int tot;
        rst_n = 1'b0;
        ep2_gate = 0; ep6_gate = 0; rdy_gate = 0; txv_gate = 0; rand_mode = 0;
        fd_in = 16'h0; ep2_empty_n = 1'b0; ep6_full_n = 1'b0;
        rx_ready = 1'b0; tx_data = 16'h0; tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(slrd_n && slwr_n && pktend_n && sloe_n && !fd_oe && fifoadr == 2'b00 && !rx_valid && !tx_ready,
            "reset_state", int'({slrd_n, slwr_n, pktend_n, sloe_n, fd_oe, fifoadr}), 7'b1111000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // three-word read
        host_q.push_back(16'h1111); exp_rx.push_back(16'h1111);
        host_q.push_back(16'h2222); exp_rx.push_back(16'h2222);
        host_q.push_back(16'h3333); exp_rx.push_back(16'h3333);
        runs.delete();
        ep2_gate = 1; rdy_gate = 1;
        wait_drain(50, "read3_drain");
        repeat (5) step();
        chk(runs.size() == 1, "read3_runs", runs.size(), 1);
        if (runs.size() >= 1) chk(runs[0].side == 1 && runs[0].len == 3, "read3_len", runs[0].len, 3);
        @(negedge clk);
        chk(sloe_n && slrd_n && !fd_oe, "read3_idle", int'({sloe_n, slrd_n, fd_oe}), 3'b110);

        // full packet: auto-committed, so no PKTEND afterwards
        ep2_gate = 0; rdy_gate = 0;
        push_tx(PKT);
        runs.delete();
        pe0 = pe_count;
        txv_gate = 1; ep6_gate = 1;
        wait_drain(600, "full_drain");
        repeat (1100) step();
        chk(pe_count == pe0, "full_no_pktend", pe_count - pe0, 0);
        chk(runs.size() == PKT / BURST, "full_runs", runs.size(), PKT / BURST);
        for (int i = 0; i < runs.size(); i++) begin
            chk(runs[i].side == 2 && runs[i].len == BURST && runs[i].post_ok, "full_burst", runs[i].len, BURST);
            if (i > 0) chk(runs[i].gap == 2, "full_gap", runs[i].gap, 2);
        end

        // short packet: single PKTEND after the idle timeout
        push_tx(5);
        wait_drain(50, "short_drain");
        pe0 = pe_count;
        n = 0;
        while (pe_count == pe0 && n < T + 100) begin
            step();
            n++;
        end
        repeat (50) step();
        chk(pe_count == pe0 + 1, "short_pktend_count", pe_count - pe0, 1);
        chk(pe_delay >= T + 1 && pe_delay <= T + 2, "short_pktend_delay", pe_delay, T + 2);

        // backpressure after word 10 of a burst
        runs.delete();
        bp_at = wcount + 10;
        bp_len = 5;
        push_tx(40);
        wait_drain(300, "bp_drain");
        repeat (4) step();
        chk(runs.size() >= 2, "bp_runs", runs.size(), 2);
        if (runs.size() >= 1) chk(runs[0].len == 10, "bp_first_len", runs[0].len, 10);
        tot = 0;
        foreach (runs[i]) tot += runs[i].len;
        chk(tot == 40, "bp_total", tot, 40);

        // fairness with both sides saturated
        runs.delete();
        push_rx(200);
        push_tx(200);
        ep2_gate = 1; rdy_gate = 1;
        n = 0;
        while (runs.size() < 5 && n < 800) begin
            step();
            n++;
        end
        chk(runs.size() >= 5, "fair_runs", runs.size(), 5);
        if (runs.size() >= 5) begin
            chk(runs[0].side == 1, "fair_first_rd", runs[0].side, 1);
            for (int i = 0; i < 5; i++) begin
                chk(runs[i].len == BURST && runs[i].post_ok, "fair_burst", runs[i].len, BURST);
                if (i > 0) chk(runs[i].side != runs[i-1].side && runs[i].gap == 2,
                               "fair_alternate", runs[i].side * 16 + runs[i].gap, 2);
            end
        end
        wait_drain(800, "fair_drain");

        // randomized traffic on both streams
        push_rx(300);
        push_tx(300);
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        ep2_gate = 1; ep6_gate = 1; rdy_gate = 1; txv_gate = 1;
        wait_drain(2000, "rand_drain");

        // reset in the middle of a write burst
        push_tx(100);
        n = 0;
        while (slwr_n && n < 50) begin
            step();
            n++;
        end
        chk(!slwr_n, "rst_wr_started", int'(slwr_n), 0);
        repeat (3) step();
        @(posedge clk);
        #1 rst_n = 1'b0;
        txv_gate = 0;
        #1;
        chk(slwr_n && !tx_ready, "rst_async", int'({slwr_n, tx_ready}), 2'b10);
        @(negedge clk);
        chk(slrd_n && slwr_n && pktend_n && sloe_n && !fd_oe && !tx_ready && fifoadr == 2'b00,
            "rst_mid_wr", int'({slrd_n, slwr_n, pktend_n, sloe_n, fd_oe, tx_ready, fifoadr}), 8'b11110000);
        src_q.delete();
        exp_tx.delete();
        host_pkt = 0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
